// File: rtl/tx_frame_scheduler.sv
// Round-robin scheduler sharing the RMII byte-to-dibit serializer between two frame sources.
// Each granted frame is sent as preamble, SFD and payload, followed by the inter-frame gap.
module tx_frame_scheduler #(
  parameter int unsigned BYTE_LEN        = 8,
  parameter int unsigned PREAMBLE_BYTES  = 7,
  parameter int unsigned IFG_BYTES       = 12,
  parameter int unsigned MAX_FRAME_BYTES = 1518
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req,
  output logic [1:0]            gnt,
  input  logic [2*BYTE_LEN-1:0] in_data,
  input  logic [1:0]            in_valid,
  input  logic [1:0]            in_last,
  output logic [1:0]            in_ready,
  input  logic                  ser_ready,
  output logic [BYTE_LEN-1:0]   ser_data,
  output logic                  ser_inclk,
  output logic                  ser_done,
  output logic                  busy,
  output logic                  abort
);

  localparam int unsigned CNT_W   = $clog2(MAX_FRAME_BYTES + 1);
  localparam int unsigned IFG_CYC = IFG_BYTES * BYTE_LEN / 2 + BYTE_LEN / 2;
  localparam int unsigned GAP_W   = $clog2(IFG_CYC + 1);

  localparam logic [BYTE_LEN-1:0] PRE_BYTE = {(BYTE_LEN/2){2'b01}};
  localparam logic [BYTE_LEN-1:0] SFD_BYTE = PRE_BYTE | {1'b1, {(BYTE_LEN-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SFD,
    S_PAY,
    S_IFG
  } state_t;

  state_t              r_state;
  logic                r_ptr;
  logic                r_sel;
  logic [CNT_W-1:0]    r_cnt;
  logic [GAP_W-1:0]    r_gap;
  logic [1:0]          r_gnt;
  logic [1:0]          r_in_ready;
  logic [BYTE_LEN-1:0] r_ser_data;
  logic                r_ser_inclk;
  logic                r_ser_done;
  logic                r_busy;
  logic                r_abort;

  logic                w_slot;
  logic                w_pick;
  logic                w_valid;
  logic                w_last;
  logic [BYTE_LEN-1:0] w_byte;
  logic [1:0]          w_sel_oh;

  // A slot needs an idle serializer and no strobe already in flight this cycle.
  assign w_slot   = ser_ready & ~r_ser_inclk;
  assign w_pick   = req[r_ptr] ? r_ptr : ~r_ptr;
  assign w_valid  = in_valid[r_sel];
  assign w_last   = in_last[r_sel];
  assign w_byte   = r_sel ? in_data[2*BYTE_LEN-1:BYTE_LEN] : in_data[BYTE_LEN-1:0];
  assign w_sel_oh = r_sel ? 2'b10 : 2'b01;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= 1'b0;
      r_sel       <= 1'b0;
      r_cnt       <= '0;
      r_gap       <= '0;
      r_gnt       <= 2'b00;
      r_in_ready  <= 2'b00;
      r_ser_data  <= '0;
      r_ser_inclk <= 1'b0;
      r_ser_done  <= 1'b0;
      r_busy      <= 1'b0;
      r_abort     <= 1'b0;
    end else begin
      r_ser_inclk <= 1'b0;
      r_in_ready  <= 2'b00;
      r_ser_done  <= 1'b0;
      r_abort     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_sel   <= w_pick;
            r_ptr   <= ~w_pick;
            r_gnt   <= w_pick ? 2'b10 : 2'b01;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_PRE;
          end
        end
        S_PRE: begin
          if (w_slot) begin
            r_ser_inclk <= 1'b1;
            r_ser_data  <= PRE_BYTE;
            if (r_cnt == CNT_W'(PREAMBLE_BYTES - 1)) begin
              r_cnt   <= '0;
              r_state <= S_SFD;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        S_SFD: begin
          if (w_slot) begin
            r_ser_inclk <= 1'b1;
            r_ser_data  <= SFD_BYTE;
            r_cnt       <= '0;
            r_state     <= S_PAY;
          end
        end
        S_PAY: begin
          // Every payload slot either loads a byte or ends the frame on underrun.
          if (w_slot) begin
            if (w_valid) begin
              r_ser_inclk <= 1'b1;
              r_ser_data  <= w_byte;
              r_in_ready  <= w_sel_oh;
              r_cnt       <= r_cnt + CNT_W'(1);
              if (w_last || (r_cnt == CNT_W'(MAX_FRAME_BYTES - 1))) begin
                r_ser_done <= 1'b1;
                r_abort    <= ~w_last;
                r_gnt      <= 2'b00;
                r_gap      <= GAP_W'(IFG_CYC - 1);
                r_state    <= S_IFG;
              end
            end else begin
              r_ser_done <= 1'b1;
              r_abort    <= 1'b1;
              r_gnt      <= 2'b00;
              r_gap      <= GAP_W'(IFG_CYC - 1);
              r_state    <= S_IFG;
            end
          end
        end
        S_IFG: begin
          if (r_gap == '0) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_gap <= r_gap - GAP_W'(1);
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_gnt   <= 2'b00;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign in_ready  = r_in_ready;
  assign ser_data  = r_ser_data;
  assign ser_inclk = r_ser_inclk;
  assign ser_done  = r_ser_done;
  assign busy      = r_busy;
  assign abort     = r_abort;

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Directed bench for tx_frame_scheduler with source models, a serializer model and a strobe scoreboard.
module tb_tx_frame_scheduler;

  localparam int unsigned BL   = 8;
  localparam int unsigned MAXB = 1518;
  localparam int unsigned GAP  = 12 * BL / 2 + BL / 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req;
  logic [1:0]    gnt;
  logic [2*BL-1:0] in_data;
  logic [1:0]    in_valid;
  logic [1:0]    in_last;
  logic [1:0]    in_ready;
  logic          ser_ready;
  logic [BL-1:0] ser_data;
  logic          ser_inclk;
  logic          ser_done;
  logic          busy;
  logic          abort;

  typedef struct packed {
    logic [7:0] d;
    logic       last;
  } src_t;

  typedef struct packed {
    logic       load;
    logic       pay;
    logic       src;
    logic [7:0] data;
    logic       done;
    logic       abrt;
    logic [1:0] gnt;
  } exp_t;

  src_t q0[$];
  src_t q1[$];
  exp_t exp_q[$];

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   done_cyc = -1;
  int   last_load = -1;
  bit   spacing_en = 1'b0;
  logic prev_inclk = 1'b0;
  int   scnt = 0;
  bit   hold = 1'b0;
  int   ready_cnt0 = 0;

  always #5 clk = ~clk;

  tx_frame_scheduler #(
    .BYTE_LEN(BL), .PREAMBLE_BYTES(7), .IFG_BYTES(12), .MAX_FRAME_BYTES(MAXB)
  ) u_dut (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .ser_ready(ser_ready), .ser_data(ser_data), .ser_inclk(ser_inclk),
    .ser_done(ser_done), .busy(busy), .abort(abort)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  task automatic src_push(input int s, input logic [7:0] d, input logic last);
    src_t e;
    e = '{d, last};
    if (s == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic push_pre(input int s);
    logic [1:0] g;
    g = (s != 0) ? 2'b10 : 2'b01;
    for (int i = 0; i < 7; i++) exp_q.push_back('{1'b1, 1'b0, 1'(s), 8'h55, 1'b0, 1'b0, g});
    exp_q.push_back('{1'b1, 1'b0, 1'(s), 8'hD5, 1'b0, 1'b0, g});
  endtask

  task automatic push_ld(input int s, input logic [7:0] d, input logic fin, input logic ab);
    logic [1:0] g;
    g = fin ? 2'b00 : ((s != 0) ? 2'b10 : 2'b01);
    exp_q.push_back('{1'b1, 1'b1, 1'(s), d, fin, ab, g});
  endtask

  // One cycle: sample outputs at negedge, score them, then update serializer and source models.
  task automatic step();
    exp_t e;
    logic [1:0] oh;
    @(negedge clk);
    cyc++;
    if (ser_inclk) chk("inclk_back_to_back", 32'(prev_inclk), 32'd0);
    if (ser_inclk && spacing_en) begin
      if (last_load >= 0) chk("load_spacing", 32'(cyc - last_load), 32'd4);
      last_load = cyc;
    end
    if (ser_inclk || ser_done || abort) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {29'd0, ser_inclk, ser_done, abort}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        oh = e.src ? 2'b10 : 2'b01;
        chk("ser_inclk", 32'(ser_inclk), 32'(e.load));
        if (e.load) chk("ser_data", 32'(ser_data), 32'(e.data));
        chk("ser_done", 32'(ser_done), 32'(e.done));
        chk("abort", 32'(abort), 32'(e.abrt));
        chk("gnt_at_event", 32'(gnt), 32'(e.gnt));
        chk("in_ready", 32'(in_ready), e.pay ? 32'(oh) : 32'd0);
      end
    end else if (in_ready != 2'b00) begin
      chk("in_ready_without_load", 32'(in_ready), 32'd0);
    end
    if (ser_done) done_cyc = cyc;
    if (in_ready[0]) begin
      ready_cnt0++;
      if (q0.size() > 0) void'(q0.pop_front());
    end
    if (in_ready[1] && q1.size() > 0) void'(q1.pop_front());
    prev_inclk = ser_inclk;
    if (ser_inclk) scnt = BL / 2;
    else if (scnt > 0) scnt--;
    ser_ready = (scnt <= 1) && !hold;
    if (q0.size() > 0) begin
      in_valid[0] = 1'b1; in_data[7:0] = q0[0].d; in_last[0] = q0[0].last;
    end else begin
      in_valid[0] = 1'b0; in_data[7:0] = 8'h00; in_last[0] = 1'b0;
    end
    if (q1.size() > 0) begin
      in_valid[1] = 1'b1; in_data[15:8] = q1[0].d; in_last[1] = q1[0].last;
    end else begin
      in_valid[1] = 1'b0; in_data[15:8] = 8'h00; in_last[1] = 1'b0;
    end
  endtask

  task automatic wait_gnt(input logic [1:0] want, input int budget);
    int n;
    n = 0;
    do begin step(); n++; end while (gnt !== want && n < budget);
    chk("gnt", 32'(gnt), 32'(want));
  endtask

  task automatic wait_idle(input int budget, input bit chk_gap);
    int n;
    n = 0;
    do begin step(); n++; end while ((busy !== 1'b0 || exp_q.size() != 0) && n < budget);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    if (chk_gap) chk("ifg_length", 32'(cyc - done_cyc), 32'(GAP));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_ser_data"}, 32'(ser_data), 32'd0);
    chk({tag, "_ser_inclk"}, 32'(ser_inclk), 32'd0);
    chk({tag, "_ser_done"}, 32'(ser_done), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_abort"}, 32'(abort), 32'd0);
  endtask

  initial begin
    int n;
    reset = 1'b0; req = 2'b00; in_data = '0; in_valid = 2'b00; in_last = 2'b00; ser_ready = 1'b1;
    repeat (3) step();
    chk_all_zero("reset");
    reset = 1'b1;

    // Three-byte frame from source 0 with gapless loads.
    src_push(0, 8'hAA, 1'b0); src_push(0, 8'hBB, 1'b0); src_push(0, 8'hCC, 1'b1);
    push_pre(0); push_ld(0, 8'hAA, 1'b0, 1'b0); push_ld(0, 8'hBB, 1'b0, 1'b0); push_ld(0, 8'hCC, 1'b1, 1'b0);
    spacing_en = 1'b1; last_load = -1;
    req = 2'b01;
    wait_gnt(2'b01, 20);
    req = 2'b00;
    wait_idle(400, 1'b1);
    spacing_en = 1'b0;

    // Round robin after a fresh reset.
    reset = 1'b0; step(); step(); reset = 1'b1;
    src_push(0, 8'h11, 1'b1); src_push(1, 8'h22, 1'b1);
    push_pre(0); push_ld(0, 8'h11, 1'b1, 1'b0);
    push_pre(1); push_ld(1, 8'h22, 1'b1, 1'b0);
    req = 2'b11;
    wait_gnt(2'b01, 20);
    wait_gnt(2'b10, 200);
    req = 2'b00;
    wait_idle(200, 1'b1);
    src_push(0, 8'h33, 1'b1);
    push_pre(0); push_ld(0, 8'h33, 1'b1, 1'b0);
    req = 2'b11;
    wait_gnt(2'b01, 20);
    req = 2'b00;
    wait_idle(200, 1'b1);

    // Underrun on the second payload slot of source 1.
    src_push(1, 8'h5A, 1'b0);
    push_pre(1); push_ld(1, 8'h5A, 1'b0, 1'b0);
    exp_q.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 2'b00});
    req = 2'b10;
    wait_gnt(2'b10, 20);
    req = 2'b00;
    wait_idle(200, 1'b1);

    // Oversized frame is cut at the byte limit.
    for (int i = 1; i <= 1520; i++) src_push(0, 8'(i), (i == 1520));
    push_pre(0);
    for (int i = 1; i <= int'(MAXB); i++) push_ld(0, 8'(i), (i == int'(MAXB)), (i == int'(MAXB)));
    ready_cnt0 = 0;
    req = 2'b01;
    wait_gnt(2'b01, 20);
    req = 2'b00;
    wait_idle(7000, 1'b1);
    chk("max_in_ready_count", 32'(ready_cnt0), 32'(MAXB));
    chk("max_src_leftover", 32'(q0.size()), 32'd2);
    q0.delete();
    step();

    // Reset during the third preamble byte.
    for (int i = 0; i < 3; i++) exp_q.push_back('{1'b1, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 2'b01});
    req = 2'b01;
    wait_gnt(2'b01, 20);
    req = 2'b00;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin step(); n++; end
    chk("pre3_reached", 32'(exp_q.size()), 32'd0);
    reset = 1'b0;
    step();
    chk_all_zero("mid_reset");
    reset = 1'b1;
    src_push(0, 8'h77, 1'b1); src_push(1, 8'h88, 1'b1);
    push_pre(0); push_ld(0, 8'h77, 1'b1, 1'b0);
    push_pre(1); push_ld(1, 8'h88, 1'b1, 1'b0);
    req = 2'b11;
    wait_gnt(2'b01, 20);
    wait_gnt(2'b10, 200);
    req = 2'b00;
    wait_idle(200, 1'b1);

    // Serializer stalls mid-payload.
    for (int i = 0; i < 6; i++) src_push(0, 8'(8'h10 + i), (i == 5));
    push_pre(0);
    for (int i = 0; i < 6; i++) push_ld(0, 8'(8'h10 + i), (i == 5), 1'b0);
    req = 2'b01;
    wait_gnt(2'b01, 20);
    req = 2'b00;
    n = 0;
    while (exp_q.size() > 4 && n < 100) begin step(); n++; end
    chk("stall_point", 32'(exp_q.size()), 32'd4);
    hold = 1'b1;
    n = 0;
    repeat (10) begin step(); if (ser_inclk) n++; end
    chk("no_load_while_stalled", 32'(n), 32'd0);
    hold = 1'b0;
    step();
    step();
    chk("resume_load", 32'(ser_inclk), 32'd1);
    wait_idle(300, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tx_frame_scheduler.md
Name: tx_frame_scheduler

Overview:
- Shares the RMII transmit byte-to-dibit serializer between two frame sources (0: encrypted datapath, 1: control/ARP path) using round-robin arbitration.
- For each granted frame it emits the preamble, then the SFD, then the requester's payload bytes, then enforces the inter-frame gap.
- Sits between the frame sources and the serializer: it drives the serializer's byte strobe, data and done inputs, and reads back its ready output.

Parameters:
- BYTE_LEN, 8, bits per byte; power of 2, ≥4.
- PREAMBLE_BYTES, 7, number of 0x55 bytes before the SFD.
- IFG_BYTES, 12, inter-frame gap in byte times; one byte time = BYTE_LEN/2 cycles.
- MAX_FRAME_BYTES, 1518, payload byte limit before forced abort.

Ports:
- clk  in  1  system clock; one dibit per cycle.
- reset  in  1  synchronous, active-low reset: sampled on the clk rising edge, asserted when 0.
- req  in  2  req[i]=1: source i has a frame pending.
- gnt  out  2  one-hot grant, held from the first preamble byte through the last payload byte.
- in_data  in  2*BYTE_LEN  source i byte on in_data[i*BYTE_LEN+:BYTE_LEN].
- in_valid  in  2  source i byte valid.
- in_last  in  2  qualifies in_valid: this is the frame's last byte.
- in_ready  out  2  1-cycle pulse: source i byte consumed this cycle.
- ser_ready  in  1  serializer idle; its output is registered and drops the cycle after a load.
- ser_data  out  BYTE_LEN  byte to serializer.
- ser_inclk  out  1  1-cycle load strobe to serializer.
- ser_done  out  1  1-cycle pulse coincident with the final byte load of a frame.
- busy  out  1  high in any state except IDLE.
- abort  out  1  1-cycle pulse when a frame is truncated.

Behaviour:
- Reset (reset=0):
  - All outputs go to 0: gnt, in_ready, ser_data, ser_inclk, ser_done, busy, abort.
  - FSM goes to IDLE and the round-robin pointer goes to 0.
  - Reset applied mid-frame takes effect at once; no closing byte and no ser_done are emitted.
- Slot rule:
  - A byte slot exists in a cycle when ser_ready=1 and ser_inclk was 0 in the previous cycle.
  - ser_inclk is never high on two consecutive cycles.
  - With the serializer free, loads occur every BYTE_LEN/2 cycles (4 cycles at the default), giving gapless dibits.
- Outputs ser_inclk, ser_data, in_ready, ser_done, abort and gnt are registered. A slot decided in cycle t strobes in cycle t+1.
- IDLE:
  - If any req bit is set, grant the requester with priority: the pointer's index first, then the other.
  - Set gnt, move to PREAMBLE, clear the byte counter.
  - The pointer becomes the loser's index, i.e. the index other than the one just granted.
  - req is sampled only in IDLE. Deasserting req after grant has no effect.
- PREAMBLE: each slot loads 0x55 and increments the counter. After PREAMBLE_BYTES loads, go to SFD.
- SFD: the next slot loads 0xD5. Go to PAYLOAD; payload counter = 0.
- PAYLOAD, at each slot, with g = the granted source:
  - in_valid[g]=1: load in_data[g] and pulse in_ready[g] in the same cycle as ser_inclk. Increment the payload counter.
    - If in_last[g]=1, pulse ser_done with this load, drop gnt and go to IFG.
    - Otherwise, if the counter reaches MAX_FRAME_BYTES, pulse ser_done and abort with this load, drop gnt and go to IFG.
  - in_valid[g]=0 at the slot (underrun): no load. Pulse abort and ser_done, drop gnt and go to IFG.
  - Bytes are consumed only at slots. The source holds data and valid until it sees in_ready.
  - in_ready to the non-granted source is always 0.
- IFG:
  - Count down IFG_BYTES*BYTE_LEN/2 + BYTE_LEN/2 cycles from entry; the extra byte time covers the dibits still shifting out of the serializer.
  - No loads during IFG. On expiry, go to IDLE. busy falls on the IDLE cycle.
  - A req held throughout is granted on the first IDLE cycle.
- Widths:
  - Byte counter: clog2(MAX_FRAME_BYTES+1) bits.
  - Gap counter: wide enough for the IFG cycle count.
  - No wrap is permitted in either.

Test Plan:
- req=01, 3-byte frame AA,BB,CC (CC last) → ser_inclk every 4 cycles; ser_data=55×7, D5, AA, BB, CC; ser_done with CC; gnt=01 until the CC load; busy low 52 cycles after the CC load.
- req=11 just after reset, both frames 1 byte → source 0 served first, then source 1; a repeat of req=11 serves source 0 again.
- Source 1 granted, in_valid[1] low at the 2nd payload slot → abort and ser_done pulse in the same cycle, no load, gnt=00, IFG entered.
- MAX_FRAME_BYTES=4, source sends 6 bytes, last on byte 6 → 4 payload loads; abort and ser_done on load 4; in_ready pulsed exactly 4 times.
- reset=0 during the 3rd preamble byte → next cycle all outputs are 0, FSM is IDLE, pointer is 0; a new req=10 starts a fresh preamble.
- ser_ready held low for 10 cycles mid-payload → no strobes; loads resume at the first slot after ser_ready rises; never two consecutive ser_inclk.
